// File: rtl/mem_wb_stage_reg.sv
// MEM/WB pipeline register: two-deep (main + skid) valid/ready stage holding the writeback tuple.
// Define MEMWB_STALL_CNT_EN to add the saturating busywait stall counter on stall_cycles.
module mem_wb_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              mem_busywait,
  input  logic              flush,
  input  logic              in_reg_write_en,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_mem_to_reg,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_rdata,
  output logic              out_valid,
  input  logic              wb_ready,
  output logic              out_reg_write_en,
  output logic [ADDR_W-1:0] out_rd_addr,
`ifdef MEMWB_STALL_CNT_EN
  output logic [DATA_W-1:0] out_write_data,
  output logic [CNT_W-1:0]  stall_cycles
`else
  output logic [DATA_W-1:0] out_write_data
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} occ_e;

  occ_e r_state, w_state_next;

  logic              r_main_we,   r_skid_we;
  logic [ADDR_W-1:0] r_main_rd,   r_skid_rd;
  logic [DATA_W-1:0] r_main_data, r_skid_data;

  logic              w_accept;
  logic              w_drain;
  logic              w_cap_we;
  logic [DATA_W-1:0] w_cap_data;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_shift_skid;

  // Capture transform: x0 is never written.
  assign w_cap_we   = in_reg_write_en & (in_rd_addr != '0);
  assign w_cap_data = in_mem_to_reg ? in_mem_rdata : in_alu_result;

  assign w_accept = in_valid & in_ready & ~mem_busywait & ~flush;
  assign w_drain  = out_valid & wb_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_main  = 1'b0;
    w_load_skid  = 1'b0;
    w_shift_skid = 1'b0;
    if (flush) begin
      w_state_next = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_state_next = StOne;
            w_load_main  = 1'b1;
          end
        end
        StOne: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = StTwo;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_state_next = StEmpty;
          end
        end
        StTwo: begin
          if (w_drain) begin
            w_state_next = StOne;
            w_shift_skid = 1'b1;
          end
        end
        default: w_state_next = StEmpty;
      endcase
    end
  end

  // in_ready depends only on registered occupancy, never on wb_ready.
  always_comb begin
    in_ready         = (r_state != StTwo);
    out_valid        = (r_state != StEmpty);
    out_reg_write_en = r_main_we & out_valid;
    out_rd_addr      = r_main_rd;
    out_write_data   = r_main_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_we   <= 1'b0;
      r_main_rd   <= '0;
      r_main_data <= '0;
      r_skid_we   <= 1'b0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
    end else begin
      if (w_load_main) begin
        r_main_we   <= w_cap_we;
        r_main_rd   <= in_rd_addr;
        r_main_data <= w_cap_data;
      end else if (w_shift_skid) begin
        r_main_we   <= r_skid_we;
        r_main_rd   <= r_skid_rd;
        r_main_data <= r_skid_data;
      end
      if (w_load_skid) begin
        r_skid_we   <= w_cap_we;
        r_skid_rd   <= in_rd_addr;
        r_skid_data <= w_cap_data;
      end
    end
  end

`ifdef MEMWB_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Flush deliberately leaves the count intact; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (in_valid && mem_busywait && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign stall_cycles = r_stall_cnt;
`else
  logic [CNT_W-1:0] w_unused_cnt;
  assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_stage_reg.sv
// Self-checking bench for mem_wb_stage_reg: queue-based occupancy model plus directed literal checks.
// Build with +define+MEMWB_STALL_CNT_EN to also check stall_cycles.
module tb_mem_wb_stage_reg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              mem_busywait;
  logic              flush;
  logic              in_reg_write_en;
  logic [ADDR_W-1:0] in_rd_addr;
  logic              in_mem_to_reg;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_mem_rdata;
  logic              out_valid;
  logic              wb_ready;
  logic              out_reg_write_en;
  logic [ADDR_W-1:0] out_rd_addr;
  logic [DATA_W-1:0] out_write_data;
`ifdef MEMWB_STALL_CNT_EN
  logic [CNT_W-1:0]  stall_cycles;
`endif

  mem_wb_stage_reg #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .mem_busywait    (mem_busywait),
    .flush           (flush),
    .in_reg_write_en (in_reg_write_en),
    .in_rd_addr      (in_rd_addr),
    .in_mem_to_reg   (in_mem_to_reg),
    .in_alu_result   (in_alu_result),
    .in_mem_rdata    (in_mem_rdata),
    .out_valid       (out_valid),
    .wb_ready        (wb_ready),
    .out_reg_write_en(out_reg_write_en),
    .out_rd_addr     (out_rd_addr),
`ifdef MEMWB_STALL_CNT_EN
    .out_write_data  (out_write_data),
    .stall_cycles    (stall_cycles)
`else
    .out_write_data  (out_write_data)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t      q[$];
  int unsigned m_stall = 0;

  always @(posedge clk) begin
    bit     acc, drn;
    entry_t e;
    acc    = in_valid && (q.size() < 2) && !mem_busywait && !flush;
    drn    = (q.size() > 0) && wb_ready;
    e.we   = in_reg_write_en && (in_rd_addr != 0);
    e.rd   = in_rd_addr;
    e.data = in_mem_to_reg ? in_mem_rdata : in_alu_result;
    if (reset) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (in_valid && mem_busywait && m_stall < 65535) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
    #1;
    check("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
    check("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      check("m_we", 64'(out_reg_write_en), 64'(q[0].we));
      check("m_rd", 64'(out_rd_addr), 64'(q[0].rd));
      check("m_data", 64'(out_write_data), 64'(q[0].data));
    end else begin
      check("m_we_idle", 64'(out_reg_write_en), 64'd0);
    end
`ifdef MEMWB_STALL_CNT_EN
    check("m_stall", 64'(stall_cycles), 64'(m_stall));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] rd,
                       input logic m2r, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] rdata);
    @(negedge clk);
    in_valid        = v;
    in_reg_write_en = we;
    in_rd_addr      = rd;
    in_mem_to_reg   = m2r;
    in_alu_result   = alu;
    in_mem_rdata    = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    wb_ready = 1'b1;
    mem_busywait = 1'b0;
    flush = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; mem_busywait = 1'b0; flush = 1'b0; wb_ready = 1'b1;
    in_reg_write_en = 1'b0; in_rd_addr = '0; in_mem_to_reg = 1'b0;
    in_alu_result = '0; in_mem_rdata = '0;

    // Reset held two cycles, then released.
    repeat (2) tick();
    @(negedge clk); reset = 1'b0;
    tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_write_data", 64'(out_write_data), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_we", 64'(out_reg_write_en), 64'd0);

    // Load result, one-cycle latency.
    drive(1, 1, 5'd7, 1, 32'h100, 32'hDEADBEEF);
    tick();
    check("load_valid", 64'(out_valid), 64'd1);
    check("load_rd", 64'(out_rd_addr), 64'd7);
    check("load_data", 64'(out_write_data), 64'hDEADBEEF);
    check("load_we", 64'(out_reg_write_en), 64'd1);
    idle(2);

    // Busywait blocks capture for three cycles.
    drive(1, 1, 5'd3, 0, 32'h55, 32'hAAAA);
    mem_busywait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bw_no_capture", 64'(out_valid), 64'd0);
      check("bw_in_ready", 64'(in_ready), 64'd1);
    end
    @(negedge clk); mem_busywait = 1'b0;
    tick();
    check("bw_capture_valid", 64'(out_valid), 64'd1);
    check("bw_capture_data", 64'(out_write_data), 64'h55);
`ifdef MEMWB_STALL_CNT_EN
    check("bw_stall_cnt", 64'(stall_cycles), 64'd3);
`endif
    idle(2);

    // Back-pressure: A, B, C offered with wb_ready low.
    @(negedge clk); wb_ready = 1'b0;
    drive(1, 1, 5'd1, 0, 32'hA, 0);
    tick();
    check("bp_a_main", 64'(out_write_data), 64'hA);
    drive(1, 1, 5'd2, 0, 32'hB, 0);
    tick();
    check("bp_full_ready", 64'(in_ready), 64'd0);
    check("bp_hold_a", 64'(out_write_data), 64'hA);
    drive(1, 1, 5'd3, 0, 32'hC, 0);
    repeat (2) tick();
    check("bp_c_held", 64'(out_write_data), 64'hA);
    check("bp_c_ready", 64'(in_ready), 64'd0);
    @(negedge clk); wb_ready = 1'b1;
    tick();
    check("bp_drain_b", 64'(out_write_data), 64'hB);
    tick();
    check("bp_drain_c", 64'(out_write_data), 64'hC);
    check("bp_c_rd", 64'(out_rd_addr), 64'd3);
    idle(1);
    check("bp_empty", 64'(out_valid), 64'd0);
    idle(1);

    // Write to x0 is suppressed.
    drive(1, 1, 5'd0, 0, 32'h1234, 0);
    tick();
    check("x0_valid", 64'(out_valid), 64'd1);
    check("x0_we", 64'(out_reg_write_en), 64'd0);
    idle(2);

    // Flush while two entries are held.
    @(negedge clk); wb_ready = 1'b0;
    drive(1, 1, 5'd4, 0, 32'h44, 0);
    tick();
    drive(1, 1, 5'd5, 0, 32'h66, 0);
    tick();
    check("fl_two", 64'(in_ready), 64'd0);
    drive(1, 1, 5'd6, 0, 32'h77, 0);
    flush = 1'b1;
    tick();
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    check("fl_we", 64'(out_reg_write_en), 64'd0);
    @(negedge clk); flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_not_captured", 64'(out_valid), 64'd0);
    idle(1);

    // Reset together with flush mid-operation.
    drive(1, 1, 5'd9, 0, 32'h99, 0);
    tick();
    @(negedge clk); reset = 1'b1; flush = 1'b1; in_valid = 1'b0;
    tick();
    check("rf_valid", 64'(out_valid), 64'd0);
    check("rf_ready", 64'(in_ready), 64'd1);
    @(negedge clk); reset = 1'b0; flush = 1'b0;
    tick();

    // Mixed traffic checked cycle by cycle against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid        = ($urandom_range(0, 3) != 0);
      in_reg_write_en = $urandom_range(0, 1);
      in_rd_addr      = ADDR_W'($urandom_range(0, 31));
      in_mem_to_reg   = $urandom_range(0, 1);
      in_alu_result   = $urandom;
      in_mem_rdata    = $urandom;
      wb_ready        = ($urandom_range(0, 2) != 0);
      mem_busywait    = ($urandom_range(0, 4) == 0);
      flush           = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage_reg.md
# mem_wb_stage_reg

Parametrised MEM/WB pipeline register for the RISC-V core, sitting between the data-memory stage and register-file writeback. Captures the writeback tuple (write enable, destination register, write data) with a valid/ready handshake. Holds results while data memory asserts busywait, and supports flush. A one-entry skid buffer gives a total depth of two, so back-pressure from writeback never loses a result.

## Interface
- DATA_W, 32: width of ALU result, memory read data and write data
- ADDR_W, 5: destination register address width
- CNT_W, 16: stall counter width (used only with MEMWB_STALL_CNT_EN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  MEM stage presents a result
- in_ready  out  1  stage can accept; equals NOT skid_valid
- mem_busywait  in  1  data memory busy; blocks capture
- flush  in  1  synchronous clear of both entries
- in_reg_write_en  in  1  instruction writes rd
- in_rd_addr  in  ADDR_W  destination register
- in_mem_to_reg  in  1  1 selects memory data, 0 selects ALU result
- in_alu_result  in  DATA_W  ALU result
- in_mem_rdata  in  DATA_W  load data
- out_valid  out  1  main entry holds a result
- wb_ready  in  1  writeback consumes the result
- out_reg_write_en  out  1  gated write enable, forced 0 when out_valid=0
- out_rd_addr  out  ADDR_W  destination register
- out_write_data  out  DATA_W  selected write data
- stall_cycles  out  CNT_W  busywait stall count; present only with MEMWB_STALL_CNT_EN

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds {we, rd, data} plus a valid bit.
- Accept = in_valid & in_ready & !mem_busywait & !flush.
- Drain = out_valid & wb_ready.
- Capture transforms:
  - data = in_mem_to_reg ? in_mem_rdata : in_alu_result
  - we = in_reg_write_en & (in_rd_addr != 0); x0 is never written.
- Occupancy states EMPTY, ONE and TWO:
  - EMPTY: accept goes to ONE, loading main.
  - ONE: accept & drain stays ONE, replacing main. Accept & !drain goes to TWO, loading skid. Drain & !accept goes to EMPTY. Otherwise stays ONE and main holds.
  - TWO: in_ready=0. Drain goes to ONE, moving skid to main. Otherwise stays TWO.
- Flush takes priority over accept and drain. Both valid bits clear, giving EMPTY next cycle. Payload registers may keep stale data; out_reg_write_en is 0 regardless.
- mem_busywait high: no capture, and in_ready is unaffected. Drain continues normally, so writeback of older results is not stalled by memory.
- Simultaneous reset and flush: reset wins, and the result is the same EMPTY state.

## Timing
- Reset values:
  - out_valid=0, out_reg_write_en=0, out_rd_addr=0, out_write_data=0
  - in_ready=1
  - stall_cycles=0
- Latency: accepted input appears on out_* the next cycle; 1 cycle.
- Throughput: one result per cycle while wb_ready=1.
- in_ready is a function of registered state only, with no combinational path from wb_ready. It falls the cycle after the skid entry fills.
- While out_valid=1 and wb_ready=0, all out_* are held stable.
- Reset mid-operation discards both entries. The first accept after reset is on the cycle reset is sampled low.

## Configuration
- MEMWB_STALL_CNT_EN defined:
  - stall_cycles increments each cycle with in_valid & mem_busywait.
  - Saturates at all-ones.
  - Cleared by reset only; flush does not clear it.
- Not defined: the stall_cycles port and its counter are absent. All other behaviour is identical.

## Test plan
- Reset held 2 cycles, then released -> out_valid=0, out_write_data=0, in_ready=1 on the first cycle after release.
- Load to rd=7, in_mem_to_reg=1, rdata=0xDEADBEEF, alu=0x100, wb_ready=1 -> next cycle out_valid=1, out_rd_addr=7, out_write_data=0xDEADBEEF, out_reg_write_en=1.
- in_valid=1 with mem_busywait=1 for 3 cycles, then 0 -> no capture during busywait, and stall_cycles=3 if enabled. Capture occurs 1 cycle after busywait drops.
- wb_ready=0 while three results A, B, C are offered back-to-back:
  - A lands in main, B in skid, then in_ready=0 and C is held upstream.
  - Raising wb_ready drains A, B, C in order, none lost.
- Write to rd=0 with in_reg_write_en=1 -> out_valid=1, out_reg_write_en=0.
- flush asserted while in TWO with in_valid=1 -> next cycle out_valid=0 and in_ready=1, and the flush-cycle input is not captured.
